// File: rtl/controladora_pkg.sv
// Shared types and defaults for the lighting controller and its button front-end.
// Pure declarations, no logic, no latency; no flow control involved.
package controladora_pkg;

  typedef enum logic [1:0] {IDLE, HELD, HELD_LONG} botao_estado_t;

  localparam int DEBOUNCE_P_DEF   = 300;
  localparam int LONG_PRESS_T_DEF = 5000;

endpackage

// File: rtl/filtro_debounce.sv
// Synchroniser + debounce filter; level follows raw after SYNC_STAGES+DEBOUNCE_P stable edges.
// No backpressure; level_nxt exposes the value level takes at the next edge.
module filtro_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_P  = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic level_nxt
);

  localparam int DW = $clog2(DEBOUNCE_P + 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_P - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [DW-1:0]          r_deb_cnt;
  logic                   w_btn_s;
  logic                   w_differ;
  logic                   w_expired;

  assign w_btn_s   = r_sync[SYNC_STAGES-1];
  assign w_differ  = (w_btn_s != r_level);
  assign w_expired = w_differ && (r_deb_cnt == CNT_LAST);
  assign level_nxt = w_expired ? w_btn_s : r_level;
  assign level     = r_level;

  // A single sample agreeing with the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], raw};
      r_level <= level_nxt;
      if (!w_differ || w_expired) r_deb_cnt <= '0;
      else                        r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/classificador_botao.sv
// Button classifier: debounces push_button and emits one short_press or long_press pulse per press.
// Pulses are registered; short aligns with btn_level falling, long LONG_PRESS_T cycles after the rise.
module classificador_botao
  import controladora_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_P   = DEBOUNCE_P_DEF,
  parameter int LONG_PRESS_T = LONG_PRESS_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  output logic btn_level,
  output logic short_press,
  output logic long_press
);

  localparam int HW = $clog2(LONG_PRESS_T + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_T);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_T - 1);

  logic          w_level;
  logic          w_level_nxt;
  logic [HW-1:0] r_hold_cnt;
  botao_estado_t r_state;
  logic          r_short;
  logic          r_long;

  filtro_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_P  (DEBOUNCE_P)
  ) u_filtro (
    .clk       (clk),
    .rst       (rst),
    .raw       (push_button),
    .level     (w_level),
    .level_nxt (w_level_nxt)
  );

  assign btn_level   = w_level;
  assign short_press = r_short;
  assign long_press  = r_long;

  always_ff @(posedge clk) begin
    if (rst || !w_level)             r_hold_cnt <= '0;
    else if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  // Decisions use level_nxt so short_press lands in the same cycle btn_level reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_short <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_short <= 1'b0;
      r_long  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_level_nxt) r_state <= HELD;
        end
        HELD: begin
          if (w_level && (r_hold_cnt == HOLD_LAST)) begin
            r_state <= HELD_LONG;
            r_long  <= 1'b1;
          end else if (!w_level_nxt) begin
            r_state <= IDLE;
            r_short <= 1'b1;
          end
        end
        HELD_LONG: begin
          if (!w_level_nxt) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classificador_botao.sv
// Directed + randomized bench for classificador_botao against a windowed reference model.
module tb_classificador_botao;

  localparam int SYNC = 2;
  localparam int P    = 4;
  localparam int LONG = 20;
  localparam int NMAX = 8192;

  logic clk = 1'b0;
  logic rst;
  logic push_button;
  logic btn_level;
  logic short_press;
  logic long_press;

  always #5 clk = ~clk;

  classificador_botao #(
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_P   (P),
    .LONG_PRESS_T (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_button (push_button),
    .btn_level   (btn_level),
    .short_press (short_press),
    .long_press  (long_press)
  );

  int checks   = 0;
  int failures = 0;

  // Reference history, indexed by clock edge number (edge 0 = before simulation).
  int   k      = 0;
  int   last_r = 0;
  logic raw_h [NMAX];
  logic lv_h  [NMAX];
  logic m_short;
  logic m_long;

  // Observed-event bookkeeping for directed checks.
  int   n_short, n_long, n_rise;
  int   rise_cyc, fall_cyc, long_cyc, short_cyc;
  logic prev_lvl;

  // Synchronised button value after edge j: the raw value SYNC-1 edges earlier, zero right after reset.
  function automatic logic s_at(input int j);
    if (j - SYNC + 1 > last_r) return raw_h[j - SYNC + 1];
    return 1'b0;
  endfunction

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    push_button = b;
    rst         = r;
    @(posedge clk);
    k++;
    raw_h[k] = b;
    if (r) begin
      last_r  = k;
      lv_h[k] = 1'b0;
      m_short = 1'b0;
      m_long  = 1'b0;
    end else begin
      logic flip;
      int   run;
      // Level flips once the synchronised input has disagreed with it for P consecutive edges.
      lv_h[k] = lv_h[k-1];
      if (k - P >= last_r) begin
        flip = 1'b1;
        for (int j = k - P; j < k; j++)
          if (s_at(j) == lv_h[k-1]) flip = 1'b0;
        if (flip) lv_h[k] = !lv_h[k-1];
      end
      run = 0;
      for (int j = k - 1; j >= 1 && lv_h[j]; j--) run++;
      m_long  = (run == LONG);
      m_short = !lv_h[k] && (run > 0) && (run < LONG);
    end
    #1;
    chk_b("btn_level", btn_level, lv_h[k]);
    chk_b("short_press", short_press, m_short);
    chk_b("long_press", long_press, m_long);
    chk_b("exclusive", short_press & long_press, 1'b0);
    if (short_press === 1'b1) begin n_short++; short_cyc = k; end
    if (long_press === 1'b1)  begin n_long++;  long_cyc  = k; end
    if (btn_level === 1'b1 && prev_lvl === 1'b0) begin n_rise++; rise_cyc = k; end
    if (btn_level === 1'b0 && prev_lvl === 1'b1) fall_cyc = k;
    prev_lvl = btn_level;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  task automatic clr();
    n_short = 0; n_long = 0; n_rise = 0;
    rise_cyc = -1; fall_cyc = -1; long_cyc = -1; short_cyc = -1;
  endtask

  initial begin
    int t0;
    int len;
    lv_h[0]  = 1'b0;
    raw_h[0] = 1'b0;
    prev_lvl = 1'b0;
    clr();

    // 1: reset with button held, then re-detection after SYNC+P edges
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    chk("rst_no_pulse", n_short + n_long + n_rise, 0);
    t0 = k;
    hold(1'b1, 8);
    chk("rst_rise_delay", rise_cyc - t0, SYNC + P);
    hold(1'b0, 12);

    // 2: clean short press
    clr(); t0 = k;
    hold(1'b1, 12);
    hold(1'b0, 12);
    chk("short_rise", rise_cyc - t0, 6);
    chk("short_fall", fall_cyc - t0, 18);
    chk("short_count", n_short, 1);
    chk("short_nolong", n_long, 0);
    chk("short_align", short_cyc, fall_cyc);

    // 3: bounce rejection
    clr();
    for (int i = 0; i < 16; i++) tick(((i / 2) % 2) == 0, 1'b0);
    hold(1'b0, 10);
    chk("bounce_rise", n_rise, 0);
    chk("bounce_pulses", n_short + n_long, 0);

    // 4: long press
    clr();
    hold(1'b1, 40);
    hold(1'b0, 12);
    chk("long_count", n_long, 1);
    chk("long_delay", long_cyc - rise_cyc, LONG);
    chk("long_noshort", n_short, 0);

    // 5: threshold boundary, D = LONG-1 then D = LONG
    clr();
    hold(1'b1, LONG - 1);
    hold(1'b0, 12);
    chk("d19_short", n_short, 1);
    chk("d19_nolong", n_long, 0);
    clr();
    hold(1'b1, LONG);
    hold(1'b0, 12);
    chk("d20_long", n_long, 1);
    chk("d20_noshort", n_short, 0);
    chk("d20_align", long_cyc, fall_cyc);

    // 6: reset mid-press with the button kept held
    clr();
    hold(1'b1, 6);
    chk("mid_rise_pre", n_rise, 1);
    hold(1'b1, 10);
    tick(1'b1, 1'b1);
    t0 = k;
    chk("mid_no_pulse", n_short + n_long, 0);
    hold(1'b1, 40);
    hold(1'b0, 12);
    chk("mid_rerise", rise_cyc - t0, SYNC + P);
    chk("mid_long_delay", long_cyc - rise_cyc, LONG);
    chk("mid_long_count", n_long, 1);
    chk("mid_noshort", n_short, 0);

    // Randomized presses with bounce, varied lengths and occasional resets
    for (int it = 0; it < 60; it++) begin
      int nb;
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) tick(1'($urandom_range(0, 1)), 1'b0);
      len = $urandom_range(1, 2 * LONG);
      for (int i = 0; i < len; i++) tick(1'b1, ($urandom_range(0, 199) == 0));
      nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) tick(1'($urandom_range(0, 1)), 1'b0);
      hold(1'b0, $urandom_range(1, 14));
    end
    hold(1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
